tdm_deframer: RTL and testbench
===============================

# tdm_deframer

Parametrised TDM channel receiver for the channel-transmission datapath. Deserialises an MSB-first serial stream into DATA_W-bit words over SLOTS timeslots per frame, and checks a per-slot parity bit in a selectable even/odd mode. A frame-lock state machine validates the sync marker and flywheels through isolated sync faults. Sits at the destination end of the link and feeds per-slot words plus error status to downstream consumers.

## Interface
- DATA_W, 8, bits per timeslot word (≥2)
- SLOTS, 32, timeslots per frame (power of two, ≥2)
- PAR_ODD, 0, 0 = even parity over word+parity bit, 1 = odd
- MISS_MAX, 2, consecutive sync faults in LOCKED before dropping to HUNT

- clk  in  1  sole clock, all state on rising edge
- reset_l  in  1  asynchronous, active-low reset
- sync  in  1  frame marker, high with the first bit of slot 0
- sdata  in  1  serial data, MSB first
- parity  in  1  parity bit for the current slot, sampled with the slot's last data bit
- err_clr  in  1  synchronous clear of err_cnt
- pdata  out  DATA_W  last completed word
- timeslot  out  $clog2(SLOTS)  slot index of pdata
- pvalid  out  1  one-cycle strobe, pdata/timeslot/par_err valid
- par_err  out  1  parity failure for pdata, qualified by pvalid
- locked  out  1  high in LOCKED state
- err_cnt  out  16  saturating count of parity errors plus sync faults

## Operation
- Counters: bit_cnt ($clog2(DATA_W)), slot_cnt ($clog2(SLOTS)). Frame = SLOTS*DATA_W cycles. Counters advance every cycle and wrap naturally; slot_cnt increments when bit_cnt wraps.
- Shift register: every edge, shreg <= {shreg[DATA_W-2:0], sdata}.
- Word completion: the edge where bit_cnt == DATA_W-1 registers {shreg[DATA_W-2:0], sdata} into pdata, slot_cnt into timeslot, and XOR(word, parity) ^ PAR_ODD into par_err. pvalid pulses only when the state is LOCKED at that edge.
- Frame boundary ("expected"): the cycle where bit_cnt == 0 and slot_cnt == 0.
- Lock FSM states:
  - HUNT: locked=0. On sync, counters load to (0,0) on that edge, then the FSM goes to CONFIRM.
  - CONFIRM: at expected, sync=1 goes to LOCKED and sync=0 goes to HUNT. Sync at any other cycle re-zeroes the counters and the FSM stays in CONFIRM.
  - LOCKED: at expected, sync=1 clears miss_cnt. Sync absent at expected, or present off-boundary, increments miss_cnt and err_cnt. Counters never realign (flywheel). miss_cnt reaching MISS_MAX goes to HUNT, with counters free-running.
- err_cnt increments on each pvalid with par_err=1 and on each LOCKED sync fault. It saturates at 16'hFFFF. err_clr has priority: same-cycle increments are dropped. If a parity error and a sync fault occur in the same cycle, err_cnt increments by 2, saturating.

## Timing
- Reset values: pdata=0, timeslot=0, pvalid=0, par_err=0, locked=0, err_cnt=0, state HUNT, counters 0, shreg 0, miss_cnt 0.
- Reset mid-frame returns to HUNT immediately. No pvalid until a full reacquire: sync, one frame in CONFIRM, then the confirming sync.
- Latency: pvalid is high in the cycle after the edge that sampled the word's last bit.
- First pvalid after lock is slot 0 of the frame whose sync caused the CONFIRM→LOCKED transition. It appears DATA_W cycles after that sync cycle.
- locked rises on the edge that samples the confirming sync and falls on the edge that reaches MISS_MAX.
- A sync fault and slot completion in the same cycle are independent. The completed word is still emitted if LOCKED held at that edge.

## Structure
- Package tdm_pkg: lock-state enum {HUNT, CONFIRM, LOCKED}, ERR_W=16 constant, default DATA_W/SLOTS.
- Sub-module tdm_lock_fsm: sync evaluation, miss_cnt, state, locked, and fault strobe.
- Datapath (counters, shreg, output registers, err_cnt) stays in tdm_deframer.

## Test plan
- Reset, then syncs every 256 cycles with slot n carrying 8'hA0+n and correct even parity. Required: locked after the second sync; pvalid every 8 cycles with timeslot 0..31, pdata 8'hA0..8'hBF, par_err=0, err_cnt=0.
- While locked, flip the parity bit of slot 5 only. Required: a single par_err with timeslot=5 and err_cnt=1; other slots clean.
- Suppress one sync. Required: locked stays 1, err_cnt+1, data alignment unchanged. Suppress two consecutive syncs. Required: locked falls at the second expected boundary and pvalid stops.
- Insert a spurious sync mid-frame while LOCKED. Required: err_cnt+1, no realignment, the following frame is decoded correctly.
- PAR_ODD=1, DATA_W=4, SLOTS=4 with odd-parity stimulus. Required: no par_err, pvalid every 4 cycles, timeslot cycles 0..3.
- Preload err_cnt to 16'hFFFE, inject 3 errors. Required: holds 16'hFFFF. Assert err_clr together with an error. Required: err_cnt=0.

Source files
------------

// File: rtl/tdm_deframer_pkg.sv
// Shared types and defaults for the TDM deframer slice.
package tdm_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        CONFIRM = 2'd1,
        LOCKED  = 2'd2
    } lock_state_t;

    localparam int ERR_W      = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SLOTS  = 32;

endpackage

// File: rtl/tdm_deframer_if.sv
// Serial line inputs and per-slot word outputs of the TDM deframer.
interface tdm_deframer_if
    import tdm_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SLOTS  = DEF_SLOTS
);
    localparam int TS_W = $clog2(SLOTS);

    logic              sync;
    logic              sdata;
    logic              parity;
    logic              err_clr;
    logic [DATA_W-1:0] pdata;
    logic [TS_W-1:0]   timeslot;
    logic              pvalid;
    logic              par_err;
    logic              locked;
    logic [ERR_W-1:0]  err_cnt;

    // Line side: drives the serial stream, consumes decoded words.
    modport master (
        output sync, sdata, parity, err_clr,
        input  pdata, timeslot, pvalid, par_err, locked, err_cnt
    );

    // Deframer side.
    modport slave (
        input  sync, sdata, parity, err_clr,
        output pdata, timeslot, pvalid, par_err, locked, err_cnt
    );
endinterface

// File: rtl/tdm_lock_fsm.sv
// Frame-lock state machine: validates the sync marker against the
// expected frame boundary and flywheels through isolated sync faults.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  HUNT    | no alignment; first sync realigns counters
//  CONFIRM | aligned once; waiting for sync exactly one frame later
//  LOCKED  | words emitted; sync faults counted, lock lost at MISS_MAX
module tdm_lock_fsm
    import tdm_pkg::*;
#(
    parameter int MISS_MAX = 2
) (
    input  logic clk,
    input  logic reset_l,
    input  logic i_sync,
    input  logic i_expected,
    output logic o_realign,
    output logic o_fault,
    output logic o_locked
);
    localparam int MISS_W = $clog2(MISS_MAX + 1);

    lock_state_t       r_state;
    logic [MISS_W-1:0] r_miss_cnt;
    logic              r_locked;

    // The sync cycle becomes bit 0 of slot 0 whenever the marker is trusted
    // for alignment (any sync in HUNT, an off-boundary sync in CONFIRM).
    assign o_realign = i_sync && ((r_state == HUNT) ||
                                  ((r_state == CONFIRM) && !i_expected));
    // In LOCKED, sync must coincide exactly with the expected boundary.
    assign o_fault   = (r_state == LOCKED) && (i_sync != i_expected);
    assign o_locked  = r_locked;

    // Lock state, miss counter and registered lock flag.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state    <= HUNT;
            r_miss_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            case (r_state)
                HUNT: begin
                    if (i_sync) r_state <= CONFIRM;
                end
                CONFIRM: begin
                    if (i_expected) begin
                        if (i_sync) begin
                            r_state    <= LOCKED;
                            r_locked   <= 1'b1;
                            r_miss_cnt <= '0;
                        end else begin
                            r_state <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (o_fault) begin
                        if (r_miss_cnt == MISS_W'(MISS_MAX - 1)) begin
                            r_state    <= HUNT;
                            r_locked   <= 1'b0;
                            r_miss_cnt <= '0;
                        end else begin
                            r_miss_cnt <= r_miss_cnt + 1'b1;
                        end
                    end else if (i_expected) begin
                        r_miss_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= HUNT;
                    r_locked   <= 1'b0;
                    r_miss_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: rtl/tdm_deframer.sv
// TDM channel receiver: deserialises an MSB-first stream into per-slot
// words, checks per-slot parity and keeps a saturating error count.
module tdm_deframer
    import tdm_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SLOTS    = DEF_SLOTS,
    parameter bit PAR_ODD  = 1'b0,
    parameter int MISS_MAX = 2
) (
    input  logic          clk,
    input  logic          reset_l,
    tdm_deframer_if.slave bus
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int TS_W  = $clog2(SLOTS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic [BIT_W-1:0]  r_bit_cnt;
    logic [TS_W-1:0]   r_slot_cnt;
    // Only the low DATA_W-1 history bits ever reach a completed word.
    logic [DATA_W-2:0] r_shreg;
    logic [DATA_W-1:0] r_pdata;
    logic [TS_W-1:0]   r_timeslot;
    logic              r_pvalid;
    logic              r_par_err;
    logic [ERR_W-1:0]  r_err_cnt;

    logic              w_expected;
    logic              w_word_done;
    logic [DATA_W-1:0] w_word;
    logic              w_par_err;
    logic              w_realign;
    logic              w_fault;
    logic              w_locked;
    logic              w_emit;
    logic [1:0]        w_err_inc;
    logic [ERR_W:0]    w_err_sum;
    logic [ERR_W-1:0]  w_err_next;

    assign w_expected  = (r_bit_cnt == '0) && (r_slot_cnt == '0);
    assign w_word_done = (r_bit_cnt == BIT_LAST);
    assign w_word      = {r_shreg, bus.sdata};
    assign w_par_err   = (^w_word) ^ bus.parity ^ PAR_ODD;
    assign w_emit      = w_word_done && w_locked;

    // A parity error and a sync fault on the same edge count twice.
    assign w_err_inc  = {1'b0, w_emit && w_par_err} + {1'b0, w_fault};
    assign w_err_sum  = {1'b0, r_err_cnt} + {{(ERR_W - 1){1'b0}}, w_err_inc};
    assign w_err_next = bus.err_clr    ? '0 :
                        w_err_sum[ERR_W] ? '1 : w_err_sum[ERR_W-1:0];

    tdm_lock_fsm #(
        .MISS_MAX (MISS_MAX)
    ) u_lock_fsm (
        .clk        (clk),
        .reset_l    (reset_l),
        .i_sync     (bus.sync),
        .i_expected (w_expected),
        .o_realign  (w_realign),
        .o_fault    (w_fault),
        .o_locked   (w_locked)
    );

    // Bit/slot counters; a trusted sync makes its own cycle bit 0 of slot 0.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_bit_cnt  <= '0;
            r_slot_cnt <= '0;
        end else if (w_realign) begin
            r_bit_cnt  <= BIT_ONE;
            r_slot_cnt <= '0;
        end else if (w_word_done) begin
            r_bit_cnt  <= '0;
            r_slot_cnt <= r_slot_cnt + 1'b1;
        end else begin
            r_bit_cnt  <= r_bit_cnt + 1'b1;
        end
    end

    // Shift register, word capture, strobe and saturating error count.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_shreg    <= '0;
            r_pdata    <= '0;
            r_timeslot <= '0;
            r_pvalid   <= 1'b0;
            r_par_err  <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_shreg  <= w_word[DATA_W-2:0];
            r_pvalid <= w_emit;
            if (w_word_done) begin
                r_pdata    <= w_word;
                r_timeslot <= r_slot_cnt;
                r_par_err  <= w_par_err;
            end
            r_err_cnt <= w_err_next;
        end
    end

    assign bus.pdata    = r_pdata;
    assign bus.timeslot = r_timeslot;
    assign bus.pvalid   = r_pvalid;
    assign bus.par_err  = r_par_err;
    assign bus.locked   = w_locked;
    assign bus.err_cnt  = r_err_cnt;
endmodule

// File: tb/tb_tdm_deframer.sv
// Frame-level directed bench for tdm_deframer: a table of per-frame stimulus
// and expectations for the 8x32 even-parity build, plus a hand-written
// sequence for a 4x4 odd-parity build.
module tb_tdm_deframer;
    import tdm_pkg::*;

    typedef struct {
        bit          do_sync;  // sync on the frame's first bit
        int          spur;     // cycle of an extra off-boundary sync, -1 none
        logic [31:0] mask;     // slots whose parity bit is inverted
        bit          l0;       // locked just after the frame's first edge
        bit          lk;       // locked at frame end
        int          nw;       // pvalid strobes inside the frame
        logic [15:0] err;      // err_cnt at frame end
        bit          pre_rst;  // partial frame then async reset beforehand
        bit          preload;  // force err_cnt to FFFE at frame start
        int          clr_at;   // cycle with err_clr high, -1 none
    } vec_t;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    always #5 clk = ~clk;

    tdm_deframer_if #(.DATA_W(8), .SLOTS(32)) m1 ();
    tdm_deframer_if #(.DATA_W(4), .SLOTS(4))  m2 ();

    tdm_deframer #(.DATA_W(8), .SLOTS(32), .PAR_ODD(1'b0), .MISS_MAX(2)) dut (
        .clk(clk), .reset_l(reset_l), .bus(m1));
    tdm_deframer #(.DATA_W(4), .SLOTS(4), .PAR_ODD(1'b1), .MISS_MAX(2)) dut2 (
        .clk(clk), .reset_l(reset_l), .bus(m2));

    int n_checks = 0;
    int n_err = 0;
    vec_t vt[19];

    function automatic vec_t mk(bit s, int spur, logic [31:0] mask, bit l0, bit lk,
                                int nw, logic [15:0] err, bit rst, bit pre, int clr);
        vec_t v;
        v.do_sync = s;  v.spur = spur; v.mask = mask; v.l0 = l0; v.lk = lk;
        v.nw = nw;      v.err = err;   v.pre_rst = rst; v.preload = pre; v.clr_at = clr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick1(input logic s, input logic d, input logic p, input logic c);
        @(negedge clk);
        m1.sync = s; m1.sdata = d; m1.parity = p; m1.err_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic tick2(input logic s, input logic d, input logic p);
        @(negedge clk);
        m2.sync = s; m2.sdata = d; m2.parity = p; m2.err_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One 256-cycle frame; slot n carries A0+n with even parity unless masked.
    task automatic run_frame(input int f, input vec_t v);
        int nw;
        int slot;
        logic [7:0] w;
        nw = 0;
        for (int c = 0; c < 256; c++) begin
            slot = c / 8;
            w = 8'hA0 + 8'(slot);
            if (c == 0 && v.preload) force dut.r_err_cnt = 16'hFFFE;
            tick1((c == 0 && v.do_sync) || (c == v.spur), w[7 - (c % 8)],
                  (^w) ^ v.mask[slot], c == v.clr_at);
            if (c == 0 && v.preload) release dut.r_err_cnt;
            if (c == 0)
                chk($sformatf("f%0d locked_after_sync_edge", f), 32'(m1.locked), 32'(v.l0));
            if (m1.pvalid) begin
                nw++;
                chk($sformatf("f%0d c%0d pvalid_phase", f, c), 32'(c % 8), 32'd7);
                chk($sformatf("f%0d c%0d timeslot", f, c), 32'(m1.timeslot), 32'(slot));
                chk($sformatf("f%0d c%0d pdata", f, c), 32'(m1.pdata), 32'(w));
                chk($sformatf("f%0d c%0d par_err", f, c), 32'(m1.par_err), 32'(v.mask[slot]));
            end
        end
        chk($sformatf("f%0d pvalid_count", f), 32'(nw), 32'(v.nw));
        chk($sformatf("f%0d locked_end", f), 32'(m1.locked), 32'(v.lk));
        chk($sformatf("f%0d err_cnt_end", f), 32'(m1.err_cnt), 32'(v.err));
    endtask

    initial begin
        //          sync spur mask    l0 lk nw  err      rst pre clr
        vt[0]  = mk(1'b1, -1, 32'h0,  1'b0, 1'b0, 0,  16'h0,    1'b0, 1'b0, -1);
        vt[1]  = mk(1'b1, -1, 32'h0,  1'b1, 1'b1, 32, 16'h0,    1'b0, 1'b0, -1);
        vt[2]  = mk(1'b1, -1, 32'h20, 1'b1, 1'b1, 32, 16'h1,    1'b0, 1'b0, -1);
        vt[3]  = mk(1'b1, -1, 32'h0,  1'b1, 1'b1, 32, 16'h1,    1'b0, 1'b0, -1);
        vt[4]  = mk(1'b0, -1, 32'h0,  1'b1, 1'b1, 32, 16'h2,    1'b0, 1'b0, -1);
        vt[5]  = mk(1'b1, -1, 32'h0,  1'b1, 1'b1, 32, 16'h2,    1'b0, 1'b0, -1);
        vt[6]  = mk(1'b1, 100, 32'h0, 1'b1, 1'b1, 32, 16'h3,    1'b0, 1'b0, -1);
        vt[7]  = mk(1'b1, -1, 32'h0,  1'b1, 1'b1, 32, 16'h3,    1'b0, 1'b0, -1);
        vt[8]  = mk(1'b0, -1, 32'h0,  1'b1, 1'b1, 32, 16'h4,    1'b0, 1'b0, -1);
        vt[9]  = mk(1'b0, -1, 32'h0,  1'b0, 1'b0, 0,  16'h5,    1'b0, 1'b0, -1);
        vt[10] = mk(1'b1, -1, 32'h0,  1'b0, 1'b0, 0,  16'h5,    1'b0, 1'b0, -1);
        vt[11] = mk(1'b1, -1, 32'h0,  1'b1, 1'b1, 32, 16'h5,    1'b0, 1'b0, -1);
        vt[12] = mk(1'b1, 39, 32'h10, 1'b1, 1'b1, 32, 16'h7,    1'b0, 1'b0, -1);
        vt[13] = mk(1'b1, -1, 32'h0,  1'b1, 1'b1, 32, 16'h7,    1'b0, 1'b0, -1);
        vt[14] = mk(1'b1, -1, 32'h0,  1'b0, 1'b0, 0,  16'h0,    1'b1, 1'b0, -1);
        vt[15] = mk(1'b1, -1, 32'h0,  1'b1, 1'b1, 32, 16'h0,    1'b0, 1'b0, -1);
        vt[16] = mk(1'b1, -1, 32'hE,  1'b1, 1'b1, 32, 16'hFFFF, 1'b0, 1'b1, -1);
        vt[17] = mk(1'b1, -1, 32'h2,  1'b1, 1'b1, 32, 16'h0,    1'b0, 1'b0, 15);
        vt[18] = mk(1'b1, -1, 32'h4,  1'b1, 1'b1, 32, 16'h1,    1'b0, 1'b0, -1);

        m1.sync = 1'b0; m1.sdata = 1'b0; m1.parity = 1'b0; m1.err_clr = 1'b0;
        m2.sync = 1'b0; m2.sdata = 1'b0; m2.parity = 1'b0; m2.err_clr = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst pdata",    32'(m1.pdata),    32'h0);
        chk("rst timeslot", 32'(m1.timeslot), 32'h0);
        chk("rst pvalid",   32'(m1.pvalid),   32'h0);
        chk("rst par_err",  32'(m1.par_err),  32'h0);
        chk("rst locked",   32'(m1.locked),   32'h0);
        chk("rst err_cnt",  32'(m1.err_cnt),  32'h0);
        chk("rst2 locked",  32'(m2.locked),   32'h0);
        chk("rst2 err_cnt", 32'(m2.err_cnt),  32'h0);
        @(negedge clk);
        reset_l = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if (vt[i].pre_rst) begin
                for (int c = 0; c < 100; c++) begin
                    logic [7:0] w;
                    w = 8'hA0 + 8'(c / 8);
                    tick1(c == 0, w[7 - (c % 8)], ^w, 1'b0);
                end
                reset_l = 1'b0;
                #1;
                chk("midrst locked",   32'(m1.locked),   32'h0);
                chk("midrst pvalid",   32'(m1.pvalid),   32'h0);
                chk("midrst err_cnt",  32'(m1.err_cnt),  32'h0);
                chk("midrst pdata",    32'(m1.pdata),    32'h0);
                chk("midrst timeslot", 32'(m1.timeslot), 32'h0);
                @(negedge clk);
                reset_l = 1'b1;
            end
            run_frame(i, vt[i]);
        end

        m1.sync = 1'b0;
        for (int f = 0; f < 5; f++) begin
            int nw2;
            nw2 = 0;
            for (int c = 0; c < 16; c++) begin
                int slot;
                logic [3:0] w2;
                logic flip;
                slot = c / 4;
                w2 = 4'h5 + 4'(slot);
                flip = (f == 4) && (slot == 2);
                tick2(c == 0, w2[3 - (c % 4)], ~(^w2) ^ flip);
                if (c == 0)
                    chk($sformatf("odd f%0d locked_after_sync_edge", f), 32'(m2.locked),
                        (f == 0) ? 32'h0 : 32'h1);
                if (m2.pvalid) begin
                    nw2++;
                    chk($sformatf("odd f%0d c%0d pvalid_phase", f, c), 32'(c % 4), 32'd3);
                    chk($sformatf("odd f%0d c%0d timeslot", f, c), 32'(m2.timeslot), 32'(slot));
                    chk($sformatf("odd f%0d c%0d pdata", f, c), 32'(m2.pdata), 32'(w2));
                    chk($sformatf("odd f%0d c%0d par_err", f, c), 32'(m2.par_err), 32'(flip));
                end
            end
            chk($sformatf("odd f%0d pvalid_count", f), 32'(nw2), (f == 0) ? 32'd0 : 32'd4);
            chk($sformatf("odd f%0d err_cnt_end", f), 32'(m2.err_cnt), (f == 4) ? 32'h1 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
